// File: rtl/dmem_arbiter.sv
// Data memory arbiter: core has priority, external master gets idle cycles
// plus a forced grant after StarveLimit denials. Stats: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int AddrWidth   = 12,
   parameter int DataWidth   = 32,
   parameter int StarveLimit = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 core_req,
   input  logic                 core_we,
   input  logic [1:0]           core_width,
   input  logic [AddrWidth-1:0] core_addr,
   input  logic [DataWidth-1:0] core_wdata,
   output logic                 core_stall,
   input  logic                 ext_req,
   input  logic                 ext_we,
   input  logic [1:0]           ext_width,
   input  logic [AddrWidth-1:0] ext_addr,
   input  logic [DataWidth-1:0] ext_wdata,
   output logic                 ext_gnt,
   output logic                 ext_rvalid,
   output logic [DataWidth-1:0] ext_rdata,
   output logic                 mem_we,
   output logic [1:0]           mem_width,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [DataWidth-1:0] mem_wdata,
   input  logic [DataWidth-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]          stat_ext_grants,
   output logic [15:0]          stat_forced
`endif
);

   typedef enum logic {NORMAL, FORCE} state_t;

   localparam logic [3:0] Limit = 4'(StarveLimit);

   state_t     state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       use_ext;

   always_comb begin
      state_d    = NORMAL;
      starve_d   = '0;
      use_ext    = 1'b0;
      core_stall = 1'b0;
      ext_gnt    = 1'b0;
      mem_we     = 1'b0;
      unique case (state_q)
         NORMAL: begin
            if (core_req) begin
               mem_we = core_we;
            end else if (ext_req) begin
               use_ext = 1'b1;
               ext_gnt = 1'b1;
            end
            if (ext_req && !ext_gnt) begin
               starve_d = (starve_q >= Limit) ? Limit : starve_q + 4'd1;
            end
            if (starve_d == Limit) state_d = FORCE;
         end
         FORCE: begin
            core_stall = 1'b1;
            if (ext_req) begin
               use_ext = 1'b1;
               ext_gnt = 1'b1;
            end
         end
      endcase
      if (use_ext) mem_we = ext_we;
      // Reset must silence the memory port and core stall immediately.
      if (!reset) begin
         core_stall = 1'b0;
         ext_gnt    = 1'b0;
         mem_we     = 1'b0;
      end
   end

   assign mem_width = use_ext ? ext_width : core_width;
   assign mem_addr  = use_ext ? ext_addr  : core_addr;
   assign mem_wdata = use_ext ? ext_wdata : core_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= NORMAL;
         starve_q   <= '0;
         ext_rvalid <= 1'b0;
         ext_rdata  <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         ext_rvalid <= ext_gnt && !ext_we;
         if (ext_gnt && !ext_we) ext_rdata <= mem_rdata;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_ext_grants <= '0;
         stat_forced     <= '0;
      end else begin
         if (ext_gnt)          stat_ext_grants <= stat_ext_grants + 16'd1;
         if (state_q == FORCE) stat_forced     <= stat_forced + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-return scoreboard.
// Build with DMEM_ARB_STATS_EN to also check the statistic counters.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req, core_we;
   logic [1:0]  core_width;
   logic [11:0] core_addr;
   logic [31:0] core_wdata;
   logic        core_stall;
   logic        ext_req, ext_we;
   logic [1:0]  ext_width;
   logic [11:0] ext_addr;
   logic [31:0] ext_wdata;
   logic        ext_gnt, ext_rvalid;
   logic [31:0] ext_rdata;
   logic        mem_we;
   logic [1:0]  mem_width;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_ext_grants, stat_forced;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] tmem [0:1023];

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_width(core_width),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(core_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_width(ext_width),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
      .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .stat_ext_grants(stat_ext_grants), .stat_forced(stat_forced)
`endif
   );

   always @(posedge clk) if (mem_we) tmem[mem_addr[11:2]] <= mem_wdata;
   assign mem_rdata = tmem[mem_addr[11:2]];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_read(input logic [31:0] d);
      exp_q.push_back(d);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("rvalid", {31'd0, ext_rvalid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) chk("rdata", ext_rdata, exp_q.pop_front());
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) tmem[i] = '0;
      reset = 1'b0;
      core_req = 0; core_we = 0; core_width = 2'b10;
      core_addr = '0; core_wdata = '0;
      ext_req = 0; ext_we = 0; ext_width = 2'b10;
      ext_addr = '0; ext_wdata = '0;
      #2;
      chk("rst_stall", core_stall, 0);
      chk("rst_gnt", ext_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rvalid", ext_rvalid, 0);
      chk("rst_rdata", ext_rdata, 0);
      step();
      reset = 1'b1;

      // external writes on idle core cycles
      ext_req = 1; ext_we = 1; ext_addr = 12'h010; ext_wdata = 32'hDEADBEEF;
      #1;
      chk("wr_gnt", ext_gnt, 1);
      chk("wr_stall", core_stall, 0);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_addr", mem_addr, 12'h010);
      step();
      ext_addr = 12'h020; ext_wdata = 32'h12345678;
      #1;
      chk("wr2_gnt", ext_gnt, 1);
      step();
      ext_req = 0;

      // core load sees the external write, core wins simultaneous request
      core_req = 1; core_we = 0; core_addr = 12'h010;
      ext_req = 1; ext_we = 0; ext_addr = 12'h020;
      #1;
      chk("core_ld", mem_rdata, 32'hDEADBEEF);
      chk("core_win_gnt", ext_gnt, 0);
      chk("core_win_stall", core_stall, 0);
      step();
      core_req = 0; ext_req = 0;
      #1;
      step();

      // back-to-back external reads
      ext_req = 1; ext_we = 0; ext_addr = 12'h010;
      #1;
      chk("rd1_gnt", ext_gnt, 1);
      expect_read(32'hDEADBEEF);
      step();
      ext_addr = 12'h020;
      #1;
      chk("rd2_gnt", ext_gnt, 1);
      expect_read(32'h12345678);
      step();
      ext_req = 0;
      #1;
      step();
      chk("rdata_hold", ext_rdata, 32'h12345678);

      // starvation: fresh reset so the statistics start at zero
      reset = 1'b0;
      step();
      reset = 1'b1;
      core_req = 1; core_we = 0; core_addr = 12'h100;
      ext_req = 1; ext_we = 0; ext_addr = 12'h010;
      for (int c = 1; c <= 10; c++) begin
         #1;
         chk($sformatf("starve_gnt%0d", c), ext_gnt, (c % 5) == 0);
         chk($sformatf("starve_stall%0d", c), core_stall, (c % 5) == 0);
         chk($sformatf("starve_addr%0d", c), mem_addr,
             ((c % 5) == 0) ? 12'h010 : 12'h100);
         if ((c % 5) == 0) expect_read(32'hDEADBEEF);
         step();
      end
`ifdef DMEM_ARB_STATS_EN
      chk("stat_forced", stat_forced, 2);
      chk("stat_ext_grants", stat_ext_grants, 2);
`endif

      // dropping ext_req restarts the starvation count
      ext_req = 0;
      #1;
      step();
      ext_req = 1;
      for (int c = 1; c <= 2; c++) begin
         #1;
         chk("drop_pre_gnt", ext_gnt, 0);
         step();
      end
      ext_req = 0;
      #1;
      step();
      ext_req = 1;
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk($sformatf("drop_gnt%0d", c), ext_gnt, c == 5);
         chk($sformatf("drop_stall%0d", c), core_stall, c == 5);
         if (c == 5) expect_read(32'hDEADBEEF);
         step();
      end

      // reset in the middle of a FORCE write
      ext_req = 0;
      #1;
      step();
      ext_req = 1; ext_we = 1; ext_addr = 12'h030; ext_wdata = 32'hCAFE0000;
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk("pre_force_gnt", ext_gnt, 0);
         step();
      end
      #1;
      chk("force_stall", core_stall, 1);
      chk("force_gnt", ext_gnt, 1);
      chk("force_mem_we", mem_we, 1);
      reset = 1'b0;
      #1;
      chk("async_stall", core_stall, 0);
      chk("async_gnt", ext_gnt, 0);
      chk("async_mem_we", mem_we, 0);
      step();
      reset = 1'b1;
      #1;
      chk("post_stall", core_stall, 0);
      chk("post_gnt", ext_gnt, 0);
      chk("post_rvalid", ext_rvalid, 0);
      chk("post_rdata", ext_rdata, 0);
      chk("no_write", tmem[12], 0);
      ext_req = 0; core_req = 0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between the single-cycle core and one external requester (debug/loader/DMA master).
- The core has priority. The external side gets any cycle in which the core makes no access.
- A starvation counter forces a one-cycle core stall so the external side is guaranteed progress.
- Sits between the core's dmem request signals and the `mem` instance. `core_stall` gates the PC register enable and the register-file write enable.

Parameters:
- AddrWidth, 12, data memory byte-address width (matches DMemAddrWidth).
- DataWidth, 32, data word width.
- StarveLimit, 4, consecutive denied external-request cycles before a forced grant; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core performs a load/store this cycle.
- core_we  in  1  core store.
- core_width  in  2  mem_width_t of core access.
- core_addr  in  AddrWidth  core address.
- core_wdata  in  DataWidth  core store data.
- core_stall  out  1  core must hold PC and suppress write-back this cycle.
- ext_req  in  1  external access pending; must hold req/we/width/addr/wdata stable until ext_gnt.
- ext_we  in  1  external store.
- ext_width  in  2  mem_width_t of external access.
- ext_addr  in  AddrWidth  external address.
- ext_wdata  in  DataWidth  external store data.
- ext_gnt  out  1  external access performed at the coming clk edge.
- ext_rvalid  out  1  one-cycle pulse: ext_rdata holds the result of a granted read.
- ext_rdata  out  DataWidth  registered read data for the external side.
- mem_we  out  1  to `mem` write_enable.
- mem_width  out  2  to `mem` width.
- mem_addr  out  AddrWidth  to `mem` address.
- mem_wdata  out  DataWidth  to `mem` data_in.
- mem_rdata  in  DataWidth  from `mem` data_out (combinational read).

Behaviour:
- Memory timing: combinational read, write on the clk rising edge. Core load data comes directly from mem_rdata; the arbiter does not register it.
- States: NORMAL, FORCE. The state register resets to NORMAL. A 4-bit starve_cnt resets to 0.
- NORMAL:
  - core_stall=0.
  - If core_req=1: the mem port is driven from the core_* inputs and ext_gnt=0.
  - Else if ext_req=1: the mem port is driven from the ext_* inputs and ext_gnt=1.
  - Else: mem_we=0, and addr/width/wdata follow the core inputs.
- starve_cnt:
  - Increments on each NORMAL cycle with ext_req=1 and ext_gnt=0.
  - Clears on any ext_gnt and on any cycle with ext_req=0.
  - Saturates at StarveLimit.
  - When it becomes equal to StarveLimit, the next state is FORCE.
- FORCE (exactly one cycle):
  - core_stall=1.
  - If ext_req=1: ext_gnt=1 and the mem port is driven from ext_*.
  - If ext_req=0 (protocol violation): mem_we=0 and ext_gnt=0.
  - Next state is always NORMAL. starve_cnt clears.
  - The core re-presents its held access in the following cycle.
- Read return: when ext_gnt=1 and ext_we=0, ext_rdata<=mem_rdata and ext_rvalid<=1 on that edge. Otherwise ext_rvalid<=0 and ext_rdata holds its value.
- Simultaneous requests in NORMAL: the core always wins. There is no combinational path from ext_* to core_stall.
- Back-to-back external accesses: allowed on consecutive grant cycles; each granted read gives one rvalid pulse, one cycle later.
- Reset asserted (reset=0), including mid-operation:
  - Combinational outputs are forced: core_stall=0, ext_gnt=0, mem_we=0.
  - Registers clear: state=NORMAL, starve_cnt=0, ext_rvalid=0, ext_rdata=0.
  - A FORCE in progress is abandoned.
- The core width/alignment semantics pass through unchanged. alignment_error remains `mem`'s responsibility.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_ext_grants (16 bits): counts ext_gnt cycles.
  - stat_forced (16 bits): counts FORCE cycles.
  - Both wrap at 16'hFFFF to 0 and clear on reset.
- When not defined, these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then core_req=0, ext_req=1, ext_we=1, ext_addr=0x010, ext_wdata=0xDEADBEEF, width word -> same-cycle ext_gnt=1, core_stall=0. A later core load from 0x010 returns 0xDEADBEEF.
- core_req=0, ext read from 0x010 -> ext_gnt=1 in cycle N; ext_rvalid=1 and ext_rdata=0xDEADBEEF in cycle N+1 only.
- core_req=1 continuously, ext_req=1, StarveLimit=4 -> ext_gnt=0 for cycles 1..4, FORCE in cycle 5 with core_stall=1 and ext_gnt=1, NORMAL in cycle 6 with the core driving mem; pattern repeats with period 5.
- ext_req drops after 2 denied cycles, then reasserts -> starve_cnt restarts from 0; FORCE occurs only after 4 further denied cycles.
- Assert reset during a FORCE cycle -> core_stall, ext_gnt and mem_we go to 0 immediately (asynchronously). After release, state is NORMAL and ext_rvalid=0.
- With DMEM_ARB_STATS_EN: run the starvation scenario for 10 cycles -> stat_forced=2, stat_ext_grants=2.
